multi_switch_debouncer: RTL and testbench

- Parametrised, multi-channel successor to the single-switch debouncer.
- Each channel has its own input synchroniser, its own 4-state debounce FSM and its own stability counter.
- The debounce period is a runtime input, so one instance serves buttons, DIP switches and mechanical contacts.
- Outputs are the clean levels plus one-cycle rise and fall pulses, for the front-panel/control logic.

---
 rtl/multi_switch_debouncer_if.sv | 38 +++
 rtl/multi_switch_debouncer.sv | 182 ++++++++++++++++++
 tb/tb_multi_switch_debouncer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/multi_switch_debouncer_if.sv
`timescale 1ns/1ps
// Switch/level bundle for multi_switch_debouncer: raw inputs and period in, clean levels and edge pulses out.
// Define MULTI_SWITCH_DEBOUNCER_GLITCH_CNT_EN to add the glitch counter clear/readback signals.
interface multi_switch_debouncer_if #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16
);
   logic [CHANNELS-1:0]   q_in;
   logic [CNT_W-1:0]      debounce_cycles;
   logic [CHANNELS-1:0]   Q;
   logic [CHANNELS-1:0]   rise_pulse;
   logic [CHANNELS-1:0]   fall_pulse;
   logic                  busy;
`ifdef MULTI_SWITCH_DEBOUNCER_GLITCH_CNT_EN
   logic                  glitch_clr;
   logic [CHANNELS*8-1:0] glitch_cnt;

   modport master (
      output q_in, debounce_cycles, glitch_clr,
      input  Q, rise_pulse, fall_pulse, busy, glitch_cnt
   );

   modport slave (
      input  q_in, debounce_cycles, glitch_clr,
      output Q, rise_pulse, fall_pulse, busy, glitch_cnt
   );
`else
   modport master (
      output q_in, debounce_cycles,
      input  Q, rise_pulse, fall_pulse, busy
   );

   modport slave (
      input  q_in, debounce_cycles,
      output Q, rise_pulse, fall_pulse, busy
   );
`endif
endinterface

// File: rtl/multi_switch_debouncer.sv
`timescale 1ns/1ps
// Multi-channel switch debouncer: per-channel synchroniser, 4-state debounce FSM and stability counter.
// Define MULTI_SWITCH_DEBOUNCER_GLITCH_CNT_EN to add per-channel saturating glitch counters.
module multi_switch_debouncer #(
   parameter int CHANNELS    = 4,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input logic                     clk,
   input logic                     reset,
   multi_switch_debouncer_if.slave bus
);

   localparam logic [1:0] IDLE_LOW  = 2'b00;
   localparam logic [1:0] WAIT_HIGH = 2'b01;
   localparam logic [1:0] IDLE_HIGH = 2'b10;
   localparam logic [1:0] WAIT_LOW  = 2'b11;

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W:0]   WIDE_ONE = (CNT_W+1)'(1);

   logic [CNT_W-1:0]    n_eff;
   logic                n_is_one;
   logic [CHANNELS-1:0] wait_next;
   logic                busy_q;

   // A period of zero behaves exactly like a period of one.
   assign n_eff    = (bus.debounce_cycles == CNT_ZERO) ? CNT_ONE : bus.debounce_cycles;
   assign n_is_one = (n_eff == CNT_ONE);

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      logic [1:0]             state_q;
      logic [1:0]             state_d;
      logic [CNT_W-1:0]       cnt_q;
      logic [CNT_W-1:0]       cnt_d;
      logic [CNT_W:0]         cnt_plus;
      logic [CNT_W-1:0]       cnt_sat;
      logic                   reached;
      logic                   level_q;
      logic                   level_d;
      logic                   rise_q;
      logic                   rise_d;
      logic                   fall_q;
      logic                   fall_d;
      logic                   abort;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.q_in[ch]};
         end
      end

      assign s = sync_q[SYNC_STAGES-1];

      // Extra bit keeps cnt+1 from wrapping before it is compared against the live period.
      assign cnt_plus = {1'b0, cnt_q} + WIDE_ONE;
      assign cnt_sat  = (&cnt_q) ? cnt_q : cnt_plus[CNT_W-1:0];
      assign reached  = (cnt_plus >= {1'b0, n_eff});

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         level_d = level_q;
         rise_d  = 1'b0;
         fall_d  = 1'b0;
         abort   = 1'b0;
         case (state_q)
            IDLE_LOW: begin
               if (s) begin
                  if (n_is_one) begin
                     state_d = IDLE_HIGH;
                     level_d = 1'b1;
                     rise_d  = 1'b1;
                     cnt_d   = CNT_ZERO;
                  end else begin
                     state_d = WAIT_HIGH;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            WAIT_HIGH: begin
               if (!s) begin
                  state_d = IDLE_LOW;
                  cnt_d   = CNT_ZERO;
                  abort   = 1'b1;
               end else if (reached) begin
                  state_d = IDLE_HIGH;
                  level_d = 1'b1;
                  rise_d  = 1'b1;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_sat;
               end
            end
            IDLE_HIGH: begin
               if (!s) begin
                  if (n_is_one) begin
                     state_d = IDLE_LOW;
                     level_d = 1'b0;
                     fall_d  = 1'b1;
                     cnt_d   = CNT_ZERO;
                  end else begin
                     state_d = WAIT_LOW;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            WAIT_LOW: begin
               if (s) begin
                  state_d = IDLE_HIGH;
                  cnt_d   = CNT_ZERO;
                  abort   = 1'b1;
               end else if (reached) begin
                  state_d = IDLE_LOW;
                  level_d = 1'b0;
                  fall_d  = 1'b1;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_sat;
               end
            end
         endcase
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state_q <= IDLE_LOW;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
         end
      end

      assign wait_next[ch]      = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
      assign bus.Q[ch]          = level_q;
      assign bus.rise_pulse[ch] = rise_q;
      assign bus.fall_pulse[ch] = fall_q;

`ifdef MULTI_SWITCH_DEBOUNCER_GLITCH_CNT_EN
      logic [7:0] gcnt_q;

      // Clear takes priority over a coincident abort; the count sticks at 255.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            gcnt_q <= 8'd0;
         end else if (bus.glitch_clr) begin
            gcnt_q <= 8'd0;
         end else if (abort && (gcnt_q != 8'hFF)) begin
            gcnt_q <= gcnt_q + 8'd1;
         end
      end

      assign bus.glitch_cnt[8*ch +: 8] = gcnt_q;
`else
      logic unused_abort;
      assign unused_abort = abort;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= |wait_next;
      end
   end

   assign bus.busy = busy_q;

endmodule

// File: tb/tb_multi_switch_debouncer.sv
`timescale 1ns/1ps
// Scoreboard bench for multi_switch_debouncer: a run-length reference model queues expected outputs per edge,
// and a monitor compares them against the DUT just after each rising edge.
module tb_multi_switch_debouncer;

   localparam int CH    = 4;
   localparam int CNT_W = 16;
   localparam int SYNC  = 2;

   typedef struct packed {
      logic [CH-1:0]   q;
      logic [CH-1:0]   rise;
      logic [CH-1:0]   fall;
      logic            busy;
      logic [CH*8-1:0] gcnt;
   } exp_t;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   exp_t expq[$];

   bit   sync_m [CH][SYNC];
   bit   lvl_m [CH];
   int   run_m [CH];
   int   glitch_m [CH];

   multi_switch_debouncer_if #(.CHANNELS(CH), .CNT_W(CNT_W)) bus ();

   multi_switch_debouncer #(
      .CHANNELS   (CH),
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         for (int k = 0; k < SYNC; k++) sync_m[c][k] = 1'b0;
         lvl_m[c]    = 1'b0;
         run_m[c]    = 0;
         glitch_m[c] = 0;
      end
   endtask

   // Reference: a level changes once the synchronised input has disagreed with it for N consecutive edges.
   task automatic model_edge(input logic [CH-1:0] q, input int n, input bit clr, output exp_t e);
      int ne;
      bit s;
      ne = (n == 0) ? 1 : n;
      e  = '0;
      for (int c = 0; c < CH; c++) begin
         s = sync_m[c][SYNC-1];
         for (int k = SYNC-1; k > 0; k--) sync_m[c][k] = sync_m[c][k-1];
         sync_m[c][0] = q[c];
         if (s != lvl_m[c]) begin
            run_m[c]++;
            if (run_m[c] >= ne) begin
               lvl_m[c] = s;
               run_m[c] = 0;
               if (s) e.rise[c] = 1'b1;
               else   e.fall[c] = 1'b1;
            end
         end else begin
            if (run_m[c] > 0 && glitch_m[c] < 255) glitch_m[c]++;
            run_m[c] = 0;
         end
         if (clr) glitch_m[c] = 0;
         e.q[c] = lvl_m[c];
         if (run_m[c] > 0) e.busy = 1'b1;
         e.gcnt[8*c +: 8] = 8'(glitch_m[c]);
      end
   endtask

   task automatic apply_stimulus(input logic [CH-1:0] q, input int n, input bit clr, input bit rstn);
      exp_t e;
      @(negedge clk);
      bus.q_in            = q;
      bus.debounce_cycles = CNT_W'(n);
`ifdef MULTI_SWITCH_DEBOUNCER_GLITCH_CNT_EN
      bus.glitch_clr      = clr;
`endif
      reset = rstn;
      if (!rstn) begin
         model_reset();
         e = '0;
      end else begin
         model_edge(q, n, clr, e);
      end
      expq.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check_output("Q", 64'(bus.Q), 64'(e.q));
            check_output("rise_pulse", 64'(bus.rise_pulse), 64'(e.rise));
            check_output("fall_pulse", 64'(bus.fall_pulse), 64'(e.fall));
            check_output("busy", 64'(bus.busy), 64'(e.busy));
`ifdef MULTI_SWITCH_DEBOUNCER_GLITCH_CNT_EN
            check_output("glitch_cnt", 64'(bus.glitch_cnt), 64'(e.gcnt));
`endif
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [CH-1:0] pat [40];
      logic [CH-1:0] target;
      logic [CH-1:0] noise;
      int            n_cur;

      errors = 0;
      checks = 0;
      reset  = 1'b0;
      bus.q_in = '0;
      bus.debounce_cycles = CNT_W'(5);
`ifdef MULTI_SWITCH_DEBOUNCER_GLITCH_CNT_EN
      bus.glitch_clr = 1'b0;
`endif
      model_reset();

      // Held in reset with all inputs high, then released: all four rise together.
      for (int i = 0; i < 3; i++) apply_stimulus(4'hF, 5, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) apply_stimulus(4'hF, 5, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) apply_stimulus(4'h0, 5, 1'b0, 1'b1);

      $display("[TB] channel 0 short glitch");
      for (int i = 0; i < 3; i++) apply_stimulus(4'h1, 5, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) apply_stimulus(4'h0, 5, 1'b0, 1'b1);

      $display("[TB] channel 1 clean pulse");
      for (int i = 0; i < 5; i++) apply_stimulus(4'h2, 5, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) apply_stimulus(4'h0, 5, 1'b0, 1'b1);

      $display("[TB] period 0 versus period 1");
      for (int i = 0; i < 40; i++) pat[i] = CH'($urandom);
      for (int i = 0; i < 40; i++) apply_stimulus(pat[i], 0, 1'b0, 1'b1);
      for (int i = 0; i < 40; i++) apply_stimulus(pat[i], 1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) apply_stimulus(4'h0, 1, 1'b0, 1'b1);

      $display("[TB] period lowered mid-wait");
      for (int i = 0; i < 42; i++) apply_stimulus(4'h4, 100, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) apply_stimulus(4'h4, 10, 1'b0, 1'b1);

      $display("[TB] async reset during WAIT_LOW");
      for (int i = 0; i < 4; i++) apply_stimulus(4'h0, 5, 1'b0, 1'b1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_output("async_reset_Q", 64'(bus.Q), 64'd0);
      check_output("async_reset_fall", 64'(bus.fall_pulse), 64'd0);
      check_output("async_reset_busy", 64'(bus.busy), 64'd0);
      for (int i = 0; i < 2; i++) apply_stimulus(4'h0, 5, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) apply_stimulus(4'h0, 5, 1'b0, 1'b1);

      $display("[TB] 300 glitches then clear");
      for (int i = 0; i < 300; i++) begin
         apply_stimulus(4'h1, 5, 1'b0, 1'b1);
         apply_stimulus(4'h0, 5, 1'b0, 1'b1);
      end
      for (int i = 0; i < 4; i++) apply_stimulus(4'h0, 5, 1'b0, 1'b1);
      apply_stimulus(4'h0, 5, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) apply_stimulus(4'h0, 5, 1'b0, 1'b1);

      $display("[TB] randomized bouncing");
      target = '0;
      n_cur  = 3;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 60 == 0) n_cur = int'($urandom_range(0, 6));
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 39) == 0) target[c] = ~target[c];
         end
         noise = CH'($urandom) & CH'($urandom) & CH'($urandom);
         apply_stimulus(target ^ noise, n_cur, ($urandom_range(0, 99) == 0), 1'b1);
      end

      @(posedge clk);
      #3;
      check_output("queue_drained", 64'(expq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
